// File: rtl/gshare_predictor.sv
// gshare direction predictor: PC^history indexed 2-bit counters, speculative GHR with
// architectural recovery. Define GSHARE_STATS_EN to build the resolved/miss counters.
module gshare_predictor #(
  parameter int         IDX_W   = 6,
  parameter int         GHR_W   = 4,
  parameter logic [1:0] RST_CNT = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_valid,
  input  logic [31:0]      f_inst,
  input  logic [31:0]      f_pc,
  output logic             pred_is_br,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  output logic [31:0]      pred_fallthru,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             r_valid,
  input  logic [IDX_W-1:0] r_idx,
  input  logic             r_taken,
  input  logic             r_pred,
  output logic             mispredict,
  output logic [31:0]      stat_br,
  output logic [31:0]      stat_miss
);

  localparam int         DEPTH     = 1 << IDX_W;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [1:0]       counters [DEPTH];
  logic [GHR_W-1:0] spec_ghr;
  logic [GHR_W-1:0] arch_ghr;
  logic [GHR_W-1:0] spec_next;
  logic [GHR_W-1:0] arch_shift;
  logic [IDX_W-1:0] ghr_ext;
  logic [IDX_W-1:0] idx;
  logic [31:0]      b_imm;
  logic             resolve_miss;

  // History is zero-extended so GHR_W == IDX_W needs no zero-width replication.
  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_W-1:0] = spec_ghr;
  end

  assign idx           = f_pc[IDX_W+1:2] ^ ghr_ext;
  assign pred_idx      = idx;
  assign pred_is_br    = f_valid && (f_inst[6:0] == OP_BRANCH);
  assign pred_taken    = pred_is_br && counters[idx][1];
  assign b_imm         = {{19{f_inst[31]}}, f_inst[31], f_inst[7], f_inst[30:25], f_inst[11:8], 1'b0};
  assign pred_fallthru = f_pc + 32'd4;
  assign pred_target   = pred_taken ? (f_pc + b_imm) : pred_fallthru;
  assign resolve_miss  = r_valid && (r_taken != r_pred);

  // A mispredicting resolve means the current fetch is wrong-path, so recovery wins.
  always_comb begin
    arch_shift    = arch_ghr << 1;
    arch_shift[0] = r_taken;
    spec_next     = spec_ghr;
    if (resolve_miss) begin
      spec_next = arch_shift;
    end else if (pred_is_br) begin
      spec_next    = spec_ghr << 1;
      spec_next[0] = pred_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      spec_ghr   <= '0;
      arch_ghr   <= '0;
      mispredict <= 1'b0;
    end else begin
      spec_ghr   <= spec_next;
      mispredict <= resolve_miss;
      if (r_valid) begin
        arch_ghr <= arch_shift;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        counters[i] <= RST_CNT;
      end
    end else if (r_valid) begin
      if (r_taken && (counters[r_idx] != 2'b11)) begin
        counters[r_idx] <= counters[r_idx] + 2'd1;
      end else if (!r_taken && (counters[r_idx] != 2'b00)) begin
        counters[r_idx] <= counters[r_idx] - 2'd1;
      end
    end
  end

`ifdef GSHARE_STATS_EN
  logic [31:0] br_count;
  logic [31:0] miss_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      br_count   <= '0;
      miss_count <= '0;
    end else begin
      if (r_valid) begin
        br_count <= br_count + 32'd1;
      end
      if (resolve_miss) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end

  assign stat_br   = br_count;
  assign stat_miss = miss_count;
`else
  assign stat_br   = 32'd0;
  assign stat_miss = 32'd0;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor (default parameters): a behavioural model
// queues expected outputs per cycle; directed scenarios plus a random phase.
module tb_gshare_predictor;

  localparam logic [31:0] BEQ = 32'h00000863;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        f_valid = 1'b0;
  logic [31:0] f_inst = '0;
  logic [31:0] f_pc = '0;
  logic        pred_is_br;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] pred_fallthru;
  logic [5:0]  pred_idx;
  logic        r_valid = 1'b0;
  logic [5:0]  r_idx = '0;
  logic        r_taken = 1'b0;
  logic        r_pred = 1'b0;
  logic        mispredict;
  logic [31:0] stat_br;
  logic [31:0] stat_miss;

  gshare_predictor dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_inst(f_inst), .f_pc(f_pc),
    .pred_is_br(pred_is_br), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_fallthru(pred_fallthru), .pred_idx(pred_idx),
    .r_valid(r_valid), .r_idx(r_idx), .r_taken(r_taken), .r_pred(r_pred),
    .mispredict(mispredict), .stat_br(stat_br), .stat_miss(stat_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vec_count = 0;
  int   miss_count = 0;

  logic [1:0]  m_table [64];
  logic [3:0]  m_spec;
  logic [3:0]  m_arch;
  logic [31:0] m_br;
  logic [31:0] m_miss;
  logic        m_mis;

  logic        last_taken;
  logic [31:0] last_target;
  logic [5:0]  last_idx;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    if (obs !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pushExpect(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic popCheck(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkOutput(e.tag, obs, e.exp);
    end
  endtask

  // One clock of stimulus: fetch and resolve inputs, model step, checks on both sides of the edge.
  task automatic applyStimulus(input logic fv, input logic [31:0] inst, input logic [31:0] pc,
                               input logic rv, input logic [5:0] ridx, input logic rt, input logic rp);
    logic [5:0]  idx;
    logic        br;
    logic        tk;
    logic [31:0] imm;
    logic [31:0] tgt;
    logic [3:0]  sh;
    @(negedge clk);
    f_valid = fv; f_inst = inst; f_pc = pc;
    r_valid = rv; r_idx = ridx; r_taken = rt; r_pred = rp;
    idx = pc[7:2] ^ {2'b00, m_spec};
    br  = fv && (inst[6:0] == 7'b1100011);
    tk  = br && m_table[idx][1];
    imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    tgt = tk ? (pc + imm) : (pc + 32'd4);
    pushExpect("pred_is_br", 32'(br));
    pushExpect("pred_taken", 32'(tk));
    pushExpect("pred_target", tgt);
    pushExpect("pred_fallthru", pc + 32'd4);
    pushExpect("pred_idx", 32'(idx));
    #1;
    last_taken = pred_taken; last_target = pred_target; last_idx = pred_idx;
    popCheck(32'(pred_is_br));
    popCheck(32'(pred_taken));
    popCheck(pred_target);
    popCheck(pred_fallthru);
    popCheck(32'(pred_idx));
    if (!rst) begin
      for (int i = 0; i < 64; i++) m_table[i] = 2'b01;
      m_spec = '0; m_arch = '0; m_br = '0; m_miss = '0; m_mis = 1'b0;
    end else begin
      if (br) m_spec = {m_spec[2:0], tk};
      m_mis = rv && (rt != rp);
      if (rv) begin
        sh = {m_arch[2:0], rt};
        m_arch = sh;
        if (rt != rp) m_spec = sh;
        if (rt && m_table[ridx] != 2'b11) m_table[ridx] = m_table[ridx] + 2'd1;
        if (!rt && m_table[ridx] != 2'b00) m_table[ridx] = m_table[ridx] - 2'd1;
`ifdef GSHARE_STATS_EN
        m_br = m_br + 32'd1;
        if (rt != rp) m_miss = m_miss + 32'd1;
`endif
      end
    end
    pushExpect("mispredict", 32'(m_mis));
    pushExpect("stat_br", m_br);
    pushExpect("stat_miss", m_miss);
    @(posedge clk);
    #1;
    popCheck(32'(mispredict));
    popCheck(stat_br);
    popCheck(stat_miss);
  endtask

  task automatic resolve(input logic [5:0] ridx, input logic rt, input logic rp);
    applyStimulus(1'b0, NOP, 32'h0, 1'b1, ridx, rt, rp);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
    applyStimulus(1'b1, inst, pc, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic applyReset(input int n);
    rst = 1'b0;
    repeat (n) applyStimulus(1'b1, BEQ, 32'h40, 1'b1, 6'd7, 1'b1, 1'b0);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] pc_for(input logic [5:0] i);
    return {24'h000020, i ^ {2'b00, m_spec}, 2'b00};
  endfunction

  initial begin
    logic [31:0] inst;
    logic [31:0] exp_br;
    logic [31:0] exp_miss;

    // Reset, then the first fetch predicts not-taken at index 0.
    applyReset(2);
    checkOutput("rst_mispredict", 32'(mispredict), 32'd0);
    fetch(32'h100, BEQ);
    checkOutput("rst_idx", 32'(last_idx), 32'h0);
    checkOutput("rst_taken", 32'(last_taken), 32'd0);
    checkOutput("rst_target", last_target, 32'h104);

    // Two taken mispredicts on entry 5 saturate it; spec_ghr recovers to 0011.
    resolve(6'd5, 1'b1, 1'b0);
    checkOutput("loop_mis1", 32'(mispredict), 32'd1);
    resolve(6'd5, 1'b1, 1'b0);
    checkOutput("loop_mis2", 32'(mispredict), 32'd1);
    fetch(32'h1018, BEQ);
    checkOutput("loop_idx", 32'(last_idx), 32'd5);
    checkOutput("loop_taken", 32'(last_taken), 32'd1);
    checkOutput("loop_target", last_target, 32'h1028);

    // History build-up to 0111 then recovery to 0000.
    applyReset(1);
    resolve(6'd5, 1'b1, 1'b1);
    resolve(6'd5, 1'b1, 1'b1);
    repeat (4) resolve(6'd40, 1'b0, 1'b0);
    fetch(32'h14, BEQ);
    checkOutput("hist_br1", 32'(last_taken), 32'd1);
    fetch(32'h10, BEQ);
    checkOutput("hist_br2", 32'(last_taken), 32'd1);
    fetch(32'h18, BEQ);
    checkOutput("hist_br3", 32'(last_taken), 32'd1);
    fetch(32'h0, NOP);
    checkOutput("hist_ghr7", 32'(last_idx), 32'd7);
    resolve(6'd5, 1'b0, 1'b1);
    checkOutput("hist_recover_mis", 32'(mispredict), 32'd1);
    fetch(32'h0, NOP);
    checkOutput("hist_ghr0", 32'(last_idx), 32'd0);

    // Same-cycle fetch and mispredicting resolve on entry 9.
    applyStimulus(1'b1, BEQ, 32'h24, 1'b1, 6'd9, 1'b1, 1'b0);
    checkOutput("simul_old_cnt", 32'(last_taken), 32'd0);
    checkOutput("simul_target", last_target, 32'h28);
    checkOutput("simul_mis", 32'(mispredict), 32'd1);
    fetch(32'h0, NOP);
    checkOutput("simul_ghr", 32'(last_idx), 32'd1);
    fetch(32'h20, BEQ);
    checkOutput("simul_new_idx", 32'(last_idx), 32'd9);
    checkOutput("simul_new_cnt", 32'(last_taken), 32'd1);

    // Saturation at 00 on entry 20.
    resolve(6'd20, 1'b1, 1'b1);
    resolve(6'd20, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      resolve(6'd20, 1'b0, 1'b1);
      fetch(pc_for(6'd20), BEQ);
    end
    resolve(6'd20, 1'b1, 1'b0);
    fetch(pc_for(6'd20), BEQ);
    checkOutput("sat_floor", 32'(last_taken), 32'd0);
    resolve(6'd20, 1'b1, 1'b0);
    fetch(pc_for(6'd20), BEQ);
    checkOutput("sat_climb", 32'(last_taken), 32'd1);

    // Stats: 10 resolves with 3 mispredicts, then a mid-run reset.
    applyReset(1);
    for (int i = 0; i < 10; i++) begin
      resolve(6'(i), 1'(i % 2), (i < 3) ? ~1'(i % 2) : 1'(i % 2));
    end
`ifdef GSHARE_STATS_EN
    exp_br = 32'd10; exp_miss = 32'd3;
`else
    exp_br = 32'd0; exp_miss = 32'd0;
`endif
    checkOutput("stats_br", stat_br, exp_br);
    checkOutput("stats_miss", stat_miss, exp_miss);
    rst = 1'b0;
    resolve(6'd3, 1'b1, 1'b0);
    rst = 1'b1;
    checkOutput("stats_rst_br", stat_br, 32'd0);
    checkOutput("stats_rst_miss", stat_miss, 32'd0);
    checkOutput("stats_rst_mis", 32'(mispredict), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      inst = $urandom;
      if ($urandom_range(0, 1) == 1) inst[6:0] = 7'b1100011;
      applyStimulus(1'($urandom_range(0, 1)), inst, $urandom,
                    1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
